class_seq_matcher: RTL and testbench
====================================

CLASS_SEQ_MATCHER -- requirements
Module: class_seq_matcher

Interface
REQ-001 SHALL have parameter IN_W, default 10, giving the input sample width (minimum 4).
REQ-002 SHALL have parameter CLS_W, default 4, giving the class width; must be at least clog2(IN_W).
REQ-003 SHALL have parameter DEPTH, default 4, giving the sequence length in classes (2..16).
REQ-004 SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-005 c  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 i  input  IN_W  sample value.
REQ-008 in_valid  input  1  sample qualifier.
REQ-009 learn_req  input  1  request to capture a new signature.
REQ-010 res  output  1  registered match pulse.
REQ-011 res_cnt  output  CNT_W  saturating count of matches.
REQ-012 cls_out  output  CLS_W  registered class of last valid sample.
REQ-013 state  output  2  FSM state: IDLE=00, LEARN=01, ARMED=10.

Function
REQ-014 Class encoding SHALL be combinational: i==0 -> 0; i in 1..3 -> 1; otherwise the index of the highest set bit of i (4..7 -> 2, 8..15 -> 3, ..., 512..1023 -> 9).
REQ-015 The history SHALL be DEPTH x CLS_W entries; on each edge with in_valid=1, hist[0] <= cls, hist[k] <= hist[k-1], oldest entry dropped; in_valid=0 SHALL hold history.
REQ-016 cls_out SHALL load cls on every edge with in_valid=1 and hold otherwise.
REQ-017 IDLE->LEARN on learn_req=1; a learn counter clears to 0.
REQ-018 In LEARN, each valid sample increments the learn counter; on the DEPTH-th valid sample, signature <= updated history (newest = that sample), state -> ARMED, fill counter cleared.
REQ-019 learn_req in LEARN SHALL be ignored; learn_req in ARMED SHALL go to LEARN, clear the learn counter, and keep the old signature until the new capture completes.
REQ-020 In ARMED, each valid sample increments the fill counter, saturating at DEPTH.
REQ-021 res SHALL go to 1 for exactly the cycle after a valid ARMED sample for which updated history == signature and updated fill == DEPTH; otherwise res = 0.
REQ-022 Matches SHALL slide: overlapping occurrences each pulse res, so consecutive valid samples can give back-to-back pulses.
REQ-023 res_cnt SHALL increment with every res pulse and saturate at 2^CNT_W-1, with no wrap.
REQ-024 No match SHALL be reported in IDLE or LEARN; the captured sequence itself SHALL NOT match at ARMED entry.
REQ-025 learn_req and in_valid in the same edge while in IDLE/ARMED: the FSM goes to LEARN and that sample counts toward neither learn nor fill; the history still shifts.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, history=0, signature=0, all counters=0, cls_out=0, res=0, res_cnt=0, regardless of clock.
REQ-027 Reset mid-LEARN or mid-ARMED SHALL discard the partial capture; no match SHALL be reported until a new LEARN completes.

Verification
REQ-028 Encoder: valid samples i = 0, 1, 3, 4, 8, 1023 -> cls_out 0, 1, 1, 2, 3, 9 on successive cycles.
REQ-029 Learn/match (DEPTH=4): learn_req, then valid 5, 20, 100, 600 -> state=10 after 4th, res=0; then repeat 5, 20, 100, 600 -> res=1 one cycle after 600 only, res_cnt=1.
REQ-030 Gaps: same as REQ-029 with in_valid=0 for 3 cycles between samples -> identical res/res_cnt, no extra pulses.
REQ-031 Sliding: signature from 4x i=5 (class 2); then 6 consecutive i=6 -> res=1 on cycles after 4th, 5th, 6th samples, res_cnt=3.
REQ-032 Reset mid-LEARN: rst asserted after 2 of 4 learn samples -> state=00, res_cnt=0, and a following i=5 stream -> res stays 0.
REQ-033 Saturation (CNT_W=8): 260 matching sliding samples -> res_cnt=255 and held, res still pulses.

Source files
------------

// File: rtl/class_seq_matcher.sv
// ---------------------------------------------------------------------------
// ClassSeqMatcher
//
// Purpose:
//   Reduces every valid input sample to a small "class" (a log2-like
//   magnitude bucket) and keeps a sliding history of the last DEPTH classes.
//   On request it learns a DEPTH-long class signature from the stream. Once
//   armed, it pulses a registered match flag whenever the most recent DEPTH
//   classes equal that signature. Matches may overlap, and a saturating
//   counter tallies them.
//
// Ports:
//   c          clock, rising-edge active
//   rst        asynchronous active-high reset
//   i          sample value (IN_W bits)
//   in_valid   sample qualifier
//   learn_req  request to capture a new signature
//   res        registered match pulse (one cycle per match)
//   res_cnt    saturating match count (CNT_W bits)
//   cls_out    registered class of the last valid sample (CLS_W bits)
//   state      FSM state: IDLE=00, LEARN=01, ARMED=10
// ---------------------------------------------------------------------------
module class_seq_matcher #(
    parameter int IN_W  = 10,
    parameter int CLS_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic [IN_W-1:0]  i,
    input  logic             in_valid,
    input  logic             learn_req,
    output logic             res,
    output logic [CNT_W-1:0] res_cnt,
    output logic [CLS_W-1:0] cls_out,
    output logic [1:0]       state
);

    // Learn and fill counters must be able to hold the value DEPTH itself.
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEARN = 2'b01,
        ARMED = 2'b10
    } state_t;

    state_t                        state_q;
    logic [DEPTH-1:0][CLS_W-1:0]   hist_q;
    logic [DEPTH-1:0][CLS_W-1:0]   hist_d;
    logic [DEPTH-1:0][CLS_W-1:0]   sig_q;
    logic [CW-1:0]                 learn_cnt_q;
    logic [CW-1:0]                 fill_cnt_q;
    logic [CW-1:0]                 fill_d;
    logic [CLS_W-1:0]              cls_d;
    logic [CLS_W-1:0]              cls_q;
    logic                          res_q;
    logic [CNT_W-1:0]              res_cnt_q;

    // Class encoder: index of the highest set bit, except that the values
    // 1..3 all map to class 1 and zero maps to class 0. Scanning upward from
    // bit 1 leaves the last set bit as the winner; i==1 is patched afterwards.
    always_comb begin
        cls_d = '0;
        for (int b = 1; b < IN_W; b++) begin
            if (i[b]) begin
                cls_d = CLS_W'(b);
            end
        end
        if (i == IN_W'(1)) begin
            cls_d = CLS_W'(1);
        end
    end

    // Next history (newest class in entry 0) and next saturating fill count.
    // The signature compare and the match decision both use these "updated"
    // values, so a match is flagged on the same edge as the completing sample.
    always_comb begin
        hist_d = in_valid ? {hist_q[DEPTH-2:0], cls_d} : hist_q;
        fill_d = (fill_cnt_q == DEPTH_C) ? fill_cnt_q : fill_cnt_q + CW'(1);
    end

    // Main sequential block: history and class registers, the IDLE/LEARN/ARMED
    // controller, and the registered match outputs. res defaults to 0 every
    // cycle so that it can only ever be a single-cycle pulse. Entering ARMED
    // clears the fill count, so the just-captured samples cannot match
    // themselves; DEPTH fresh samples are needed first. A learn request
    // arriving with a valid sample moves to LEARN without counting that
    // sample, although the history still shifts.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hist_q      <= '0;
            sig_q       <= '0;
            learn_cnt_q <= '0;
            fill_cnt_q  <= '0;
            cls_q       <= '0;
            res_q       <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            res_q <= 1'b0;
            if (in_valid) begin
                hist_q <= hist_d;
                cls_q  <= cls_d;
            end
            case (state_q)
                IDLE: begin
                    if (learn_req) begin
                        state_q     <= LEARN;
                        learn_cnt_q <= '0;
                    end
                end
                LEARN: begin
                    if (in_valid) begin
                        learn_cnt_q <= learn_cnt_q + CW'(1);
                        if (learn_cnt_q == DEPTH_C - CW'(1)) begin
                            sig_q      <= hist_d;
                            state_q    <= ARMED;
                            fill_cnt_q <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (learn_req) begin
                        state_q     <= LEARN;
                        learn_cnt_q <= '0;
                    end else if (in_valid) begin
                        fill_cnt_q <= fill_d;
                        if ((hist_d == sig_q) && (fill_d == DEPTH_C)) begin
                            res_q <= 1'b1;
                            if (res_cnt_q != {CNT_W{1'b1}}) begin
                                res_cnt_q <= res_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res     = res_q;
    assign res_cnt = res_cnt_q;
    assign cls_out = cls_q;
    assign state   = state_q;

endmodule

// File: tb/tb_class_seq_matcher.sv
// ---------------------------------------------------------------------------
// tb_class_seq_matcher
//
// Self-checking bench for class_seq_matcher with default parameters
// (IN_W=10, CLS_W=4, DEPTH=4, CNT_W=8). A table of vectors covers the
// encoder and a basic learn/match run. Hand-written sequences cover
// gapped input, sliding matches, learn restarts, async reset and counter
// saturation. Each driven cycle pushes its expected outputs onto a queue,
// and the entry is popped and compared once the clock edge has produced
// the DUT's result.
// ---------------------------------------------------------------------------
module tb_class_seq_matcher;

    logic       c = 1'b0;
    logic       rst;
    logic [9:0] i;
    logic       inValid;
    logic       learnReq;
    logic       res;
    logic [7:0] resCnt;
    logic [3:0] clsOut;
    logic [1:0] state;

    typedef struct {
        logic       expRes;
        logic [1:0] expState;
        logic [3:0] expCls;
        logic [7:0] expCnt;
    } exp_t;

    typedef struct {
        logic       learn;
        logic       valid;
        logic [9:0] sample;
        exp_t       e;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[16];
    int   checkCount = 0;
    int   passCount  = 0;

    class_seq_matcher #(
        .IN_W(10), .CLS_W(4), .DEPTH(4), .CNT_W(8)
    ) dut (
        .c(c), .rst(rst), .i(i), .in_valid(inValid), .learn_req(learnReq),
        .res(res), .res_cnt(resCnt), .cls_out(clsOut), .state(state)
    );

    // Free-running clock, 10 time-unit period.
    always #5 c = ~c;

    function automatic exp_t mk(logic r, logic [1:0] st, logic [3:0] cl, logic [7:0] cn);
        exp_t e;
        e.expRes = r; e.expState = st; e.expCls = cl; e.expCnt = cn;
        return e;
    endfunction

    function automatic vec_t mkv(logic l, logic v, logic [9:0] s, exp_t e);
        vec_t x;
        x.learn = l; x.valid = v; x.sample = s; x.e = e;
        return x;
    endfunction

    // Compares one observed value against its expectation.
    task automatic checkOutput(string name, int actual, int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and records what the edge should produce.
    // The DUT is then sampled 1 time unit after the rising edge.
    task automatic applyStimulus(string tag, logic l, logic v, logic [9:0] s, exp_t e);
        exp_t got;
        learnReq = l;
        inValid  = v;
        i        = s;
        expQ.push_back(e);
        @(posedge c);
        #1;
        got = expQ.pop_front();
        checkOutput({tag, ".res"},   int'(res),    int'(got.expRes));
        checkOutput({tag, ".state"}, int'(state),  int'(got.expState));
        checkOutput({tag, ".cls"},   int'(clsOut), int'(got.expCls));
        checkOutput({tag, ".cnt"},   int'(resCnt), int'(got.expCnt));
    endtask

    // Raises reset mid-cycle, checks that the outputs clear immediately
    // without any clock edge, then releases it just after an edge.
    task automatic applyReset(string tag);
        learnReq = 1'b0;
        inValid  = 1'b0;
        i        = '0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput({tag, ".rstState"}, int'(state),  0);
        checkOutput({tag, ".rstRes"},   int'(res),    0);
        checkOutput({tag, ".rstCnt"},   int'(resCnt), 0);
        checkOutput({tag, ".rstCls"},   int'(clsOut), 0);
        @(posedge c);
        #1;
        rst = 1'b0;
    endtask

    // Learns a signature from four copies of the same sample.
    task automatic learnFour(string tag, logic [9:0] s, logic [3:0] cl);
        applyStimulus({tag, ".req"}, 1'b1, 1'b0, '0, mk(0, 2'b01, 4'd0, 8'd0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus({tag, ".lrn"}, 1'b0, 1'b1, s, mk(0, (k == 3) ? 2'b10 : 2'b01, cl, 8'd0));
        end
    endtask

    logic [9:0] seqSample[4];
    logic [3:0] seqClass[4];

    initial begin
        rst      = 1'b1;
        learnReq = 1'b0;
        inValid  = 1'b0;
        i        = '0;
        seqSample[0] = 10'd5;   seqClass[0] = 4'd2;
        seqSample[1] = 10'd20;  seqClass[1] = 4'd4;
        seqSample[2] = 10'd100; seqClass[2] = 4'd6;
        seqSample[3] = 10'd600; seqClass[3] = 4'd9;

        // Encoder sweep, then a learn of 5,20,100,600, a matching repeat,
        // and a following non-matching sample.
        vecs[0]  = mkv(0, 1, 10'd0,    mk(0, 2'b00, 4'd0, 8'd0));
        vecs[1]  = mkv(0, 1, 10'd1,    mk(0, 2'b00, 4'd1, 8'd0));
        vecs[2]  = mkv(0, 1, 10'd3,    mk(0, 2'b00, 4'd1, 8'd0));
        vecs[3]  = mkv(0, 1, 10'd4,    mk(0, 2'b00, 4'd2, 8'd0));
        vecs[4]  = mkv(0, 1, 10'd8,    mk(0, 2'b00, 4'd3, 8'd0));
        vecs[5]  = mkv(0, 1, 10'd1023, mk(0, 2'b00, 4'd9, 8'd0));
        vecs[6]  = mkv(1, 0, 10'd0,    mk(0, 2'b01, 4'd9, 8'd0));
        vecs[7]  = mkv(0, 1, 10'd5,    mk(0, 2'b01, 4'd2, 8'd0));
        vecs[8]  = mkv(0, 1, 10'd20,   mk(0, 2'b01, 4'd4, 8'd0));
        vecs[9]  = mkv(0, 1, 10'd100,  mk(0, 2'b01, 4'd6, 8'd0));
        vecs[10] = mkv(0, 1, 10'd600,  mk(0, 2'b10, 4'd9, 8'd0));
        vecs[11] = mkv(0, 1, 10'd5,    mk(0, 2'b10, 4'd2, 8'd0));
        vecs[12] = mkv(0, 1, 10'd20,   mk(0, 2'b10, 4'd4, 8'd0));
        vecs[13] = mkv(0, 1, 10'd100,  mk(0, 2'b10, 4'd6, 8'd0));
        vecs[14] = mkv(0, 1, 10'd600,  mk(1, 2'b10, 4'd9, 8'd1));
        vecs[15] = mkv(0, 1, 10'd7,    mk(0, 2'b10, 4'd2, 8'd1));

        #3;
        applyReset("init");
        for (int v = 0; v < 16; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].learn, vecs[v].valid, vecs[v].sample, vecs[v].e);
        end

        // Same learn/match with three idle cycles after every sample.
        applyReset("gap");
        applyStimulus("gap.req", 1'b1, 1'b0, '0, mk(0, 2'b01, 4'd0, 8'd0));
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                logic [1:0] st;
                logic       r;
                logic [7:0] cn;
                st = (p == 0 && k < 3) ? 2'b01 : 2'b10;
                r  = (p == 1 && k == 3);
                cn = (p == 1 && k == 3) ? 8'd1 : 8'd0;
                applyStimulus("gap.smp", 1'b0, 1'b1, seqSample[k], mk(r, st, seqClass[k], cn));
                for (int g = 0; g < 3; g++) begin
                    applyStimulus("gap.idle", 1'b0, 1'b0, 10'd999, mk(0, st, seqClass[k], cn));
                end
            end
        end

        // Sliding matches: signature of four class-2 samples, then six more.
        applyReset("slide");
        learnFour("slide", 10'd5, 4'd2);
        for (int k = 0; k < 6; k++) begin
            applyStimulus("slide.run", 1'b0, 1'b1, 10'd6,
                          mk(k >= 3, 2'b10, 4'd2, (k >= 3) ? 8'(k - 2) : 8'd0));
        end

        // Relearn from ARMED with a simultaneous valid sample: that sample
        // is not counted, so four more samples are needed to re-arm, and
        // then four fresh samples before the next match.
        applyStimulus("relearn.req", 1'b1, 1'b1, 10'd6, mk(0, 2'b01, 4'd2, 8'd3));
        for (int k = 0; k < 4; k++) begin
            applyStimulus("relearn.lrn", 1'b0, 1'b1, 10'd6, mk(0, (k == 3) ? 2'b10 : 2'b01, 4'd2, 8'd3));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus("relearn.run", 1'b0, 1'b1, 10'd6, mk(k == 3, 2'b10, 4'd2, (k == 3) ? 8'd4 : 8'd3));
        end

        // Reset in the middle of a learn discards it; no matches follow.
        applyReset("midlearn.pre");
        applyStimulus("midlearn.req", 1'b1, 1'b0, '0, mk(0, 2'b01, 4'd0, 8'd0));
        applyStimulus("midlearn.s0", 1'b0, 1'b1, 10'd5, mk(0, 2'b01, 4'd2, 8'd0));
        applyStimulus("midlearn.s1", 1'b0, 1'b1, 10'd5, mk(0, 2'b01, 4'd2, 8'd0));
        applyReset("midlearn");
        for (int k = 0; k < 8; k++) begin
            applyStimulus("midlearn.run", 1'b0, 1'b1, 10'd5, mk(0, 2'b00, 4'd2, 8'd0));
        end

        // Counter saturation: 260 sliding matches, count stops at 255.
        applyReset("sat");
        learnFour("sat", 10'd5, 4'd2);
        for (int n = 0; n < 263; n++) begin
            int cn;
            cn = (n >= 3) ? n - 2 : 0;
            if (cn > 255) cn = 255;
            applyStimulus("sat.run", 1'b0, 1'b1, 10'd5, mk(n >= 3, 2'b10, 4'd2, 8'(cn)));
        end
        applyStimulus("sat.hold", 1'b0, 1'b0, 10'd0, mk(0, 2'b10, 4'd2, 8'd255));

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
